// File: rtl/sc_leveltimer_pkg.sv
// sc_leveltimer_pkg: state encoding and default sizing for the level timer
package sc_leveltimer_pkg;
  localparam int TIMER_WIDTH_DEF = 32;
  localparam int LEVEL_WIDTH_DEF = 8;
  localparam int LOADS_PER_LEVEL_DEF = 16;
  localparam int LEVEL_MAX_DEF = 59;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/sc_reloadcounter.sv
// sc_reloadcounter: down-counter that reloads on load or when it expires while enabled
module sc_reloadcounter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);
  logic [W-1:0] cnt;
  assign zero = cnt == '0;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load || (en && zero)) cnt <= value;
    else if (en) cnt <= cnt - W'(1);
endmodule

// File: rtl/sc_leveltimer.sv
// sc_leveltimer: periodic LOAD tick generator with level counting, pause and terminal level
module sc_leveltimer
  import sc_leveltimer_pkg::*;
#(
  parameter int TIMER_WIDTH = TIMER_WIDTH_DEF,
  parameter int LEVEL_WIDTH = LEVEL_WIDTH_DEF,
  parameter int LOADS_PER_LEVEL = LOADS_PER_LEVEL_DEF,
  parameter int LEVEL_MAX = LEVEL_MAX_DEF
) (
  input  logic                   SC_LEVELTIMER_CLOCK_50,
  input  logic                   SC_LEVELTIMER_RESET_InHigh,
  input  logic                   SC_LEVELTIMER_START_InLow,
  input  logic                   SC_LEVELTIMER_PAUSE_InHigh,
  input  logic [TIMER_WIDTH-1:0] SC_LEVELTIMER_PERIOD_IN,
  output logic                   SC_LEVELTIMER_LOAD_OUT,
  output logic [LEVEL_WIDTH-1:0] SC_LEVELTIMER_LEVEL_OUT,
  output logic                   SC_LEVELTIMER_LEVELUP_OUT,
  output logic [1:0]             SC_LEVELTIMER_STATE_OUT
);
  localparam int LCW = LOADS_PER_LEVEL > 1 ? $clog2(LOADS_PER_LEVEL) : 1;
  localparam logic [LCW-1:0] LC_LAST = LCW'(LOADS_PER_LEVEL - 1);
  localparam logic [LEVEL_WIDTH-1:0] LV_LAST = LEVEL_WIDTH'(LEVEL_MAX - 1);
  state_t state, state_nx;
  logic go, active, zero, tick, lv_wrap;
  logic [LCW-1:0] load_cnt;
  logic [TIMER_WIDTH-1:0] reload;
  // Pause is checked on the edge itself, so a paused edge never ticks and the
  // edge that releases pause already counts.
  assign go = state == IDLE && !SC_LEVELTIMER_START_InLow;
  assign active = (state == RUN || state == PAUSE) && !SC_LEVELTIMER_PAUSE_InHigh;
  assign tick = active && zero;
  assign lv_wrap = tick && load_cnt == LC_LAST;
  assign reload = SC_LEVELTIMER_PERIOD_IN <= TIMER_WIDTH'(1) ? '0
                : SC_LEVELTIMER_PERIOD_IN - TIMER_WIDTH'(1);
  assign SC_LEVELTIMER_STATE_OUT = state;
  sc_reloadcounter #(.W(TIMER_WIDTH)) u_cnt (
    .clk  (SC_LEVELTIMER_CLOCK_50),
    .rst  (SC_LEVELTIMER_RESET_InHigh),
    .en   (active),
    .load (go),
    .value(reload),
    .zero (zero)
  );
  always_comb
    state_nx = state == IDLE ? (go ? RUN : IDLE)
             : state == DONE ? DONE
             : (lv_wrap && SC_LEVELTIMER_LEVEL_OUT == LV_LAST) ? DONE
             : SC_LEVELTIMER_PAUSE_InHigh ? PAUSE : RUN;
  always_ff @(posedge SC_LEVELTIMER_CLOCK_50)
    if (SC_LEVELTIMER_RESET_InHigh) begin
      state <= IDLE;
      load_cnt <= '0;
      SC_LEVELTIMER_LEVEL_OUT <= '0;
      SC_LEVELTIMER_LOAD_OUT <= 1'b0;
      SC_LEVELTIMER_LEVELUP_OUT <= 1'b0;
    end else begin
      state <= state_nx;
      SC_LEVELTIMER_LOAD_OUT <= tick;
      SC_LEVELTIMER_LEVELUP_OUT <= lv_wrap;
      if (tick) load_cnt <= lv_wrap ? '0 : load_cnt + LCW'(1);
      if (lv_wrap) SC_LEVELTIMER_LEVEL_OUT <= SC_LEVELTIMER_LEVEL_OUT + LEVEL_WIDTH'(1);
    end
endmodule

// File: tb/tb_sc_leveltimer.sv
// tb_sc_leveltimer: directed scenarios with a per-cycle expectation queue
module tb_sc_leveltimer;
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_DONE = 2'd3;
  typedef struct packed {
    logic       l;
    logic       u;
    logic [7:0] lv;
    logic [1:0] st;
  } exp_t;
  logic clk = 0, rst = 1, start_n = 1, pause = 0;
  logic [31:0] period = 32'd4;
  logic load_out, levelup_out;
  logic [7:0] level_out;
  logic [1:0] state_out;
  exp_t q[$];
  string tq[$];
  int vectors = 0, miscompares = 0;
  sc_leveltimer dut (
    .SC_LEVELTIMER_CLOCK_50    (clk),
    .SC_LEVELTIMER_RESET_InHigh(rst),
    .SC_LEVELTIMER_START_InLow (start_n),
    .SC_LEVELTIMER_PAUSE_InHigh(pause),
    .SC_LEVELTIMER_PERIOD_IN   (period),
    .SC_LEVELTIMER_LOAD_OUT    (load_out),
    .SC_LEVELTIMER_LEVEL_OUT   (level_out),
    .SC_LEVELTIMER_LEVELUP_OUT (levelup_out),
    .SC_LEVELTIMER_STATE_OUT   (state_out)
  );
  always #5 clk = ~clk;
  task automatic cyc(input logic l, input logic u, input logic [7:0] lv, input logic [1:0] st,
                     input string tag);
    exp_t e, o;
    string t;
    q.push_back('{l: l, u: u, lv: lv, st: st});
    tq.push_back(tag);
    @(posedge clk);
    #1;
    e = q.pop_front();
    t = tq.pop_front();
    o = '{l: load_out, u: levelup_out, lv: level_out, st: state_out};
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: load/lvup/level/state observed %b/%b/%0d/%0d expected %b/%b/%0d/%0d",
             t, o.l, o.u, o.lv, o.st, e.l, e.u, e.lv, e.st);
    end
  endtask
  task automatic do_reset(input string tag);
    rst = 1;
    cyc(0, 0, 0, S_IDLE, tag);
    rst = 0;
  endtask
  task automatic do_start(input string tag);
    start_n = 0;
    cyc(0, 0, 0, S_RUN, tag);
    start_n = 1;
  endtask
  initial begin
    do_reset("reset");
    cyc(0, 0, 0, S_IDLE, "idle_no_start");
    cyc(0, 0, 0, S_IDLE, "idle_no_start");
    period = 4;
    do_start("start_p4");
    for (int k = 1; k <= 12; k++) cyc(k % 4 == 0, 0, 0, S_RUN, "period4_tick");
    start_n = 0;
    cyc(0, 0, 0, S_RUN, "start_ignored_in_run");
    start_n = 1;
    do_reset("reset_p4");
    period = 1;
    do_start("start_p1");
    for (int k = 1; k <= 83; k++)
      cyc(1, k % 16 == 0, 8'(k / 16), S_RUN, "period1_level");
    rst = 1;
    start_n = 0;
    pause = 1;
    cyc(0, 0, 0, S_IDLE, "reset_mid_run_overrides");
    rst = 0;
    start_n = 1;
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, S_IDLE, "pause_ignored_in_idle");
    pause = 0;
    cyc(0, 0, 0, S_IDLE, "stay_idle");
    do_reset("reset_before_pause");
    period = 3;
    do_start("start_p3");
    cyc(0, 0, 0, S_RUN, "p3_count");
    cyc(0, 0, 0, S_RUN, "p3_count");
    pause = 1;
    for (int k = 0; k < 10; k++) cyc(0, 0, 0, S_PAUSE, "paused_no_tick");
    pause = 0;
    cyc(1, 0, 0, S_RUN, "tick_after_pause");
    cyc(0, 0, 0, S_RUN, "p3_after_pause");
    cyc(0, 0, 0, S_RUN, "p3_after_pause");
    cyc(1, 0, 0, S_RUN, "p3_after_pause_tick");
    pause = 1;
    cyc(0, 0, 0, S_PAUSE, "pause_mid_period");
    pause = 0;
    cyc(0, 0, 0, S_RUN, "resume_mid_period");
    cyc(0, 0, 0, S_RUN, "resume_mid_period");
    cyc(1, 0, 0, S_RUN, "resume_tick");
    do_reset("reset_before_period_change");
    period = 8;
    do_start("start_p8");
    for (int k = 1; k <= 3; k++) cyc(0, 0, 0, S_RUN, "p8_count");
    period = 2;
    for (int k = 4; k <= 8; k++) cyc(k == 8, 0, 0, S_RUN, "p8_interval_kept");
    for (int k = 1; k <= 6; k++) cyc(k % 2 == 0, 0, 0, S_RUN, "p2_after_reload");
    do_reset("reset_before_zero_period");
    period = 0;
    do_start("start_p0");
    for (int k = 1; k <= 3; k++) cyc(1, 0, 0, S_RUN, "period0_as_1");
    do_reset("reset_before_max");
    period = 1;
    do_start("start_max");
    for (int k = 1; k < 944; k++)
      cyc(1, k % 16 == 0, 8'(k / 16), S_RUN, "run_to_max");
    cyc(1, 1, 8'd59, S_DONE, "reach_level_max");
    for (int k = 0; k < 100; k++) begin
      start_n = k[0];
      pause = k[1];
      cyc(0, 0, 8'd59, S_DONE, "done_hold");
    end
    start_n = 1;
    pause = 0;
    do_reset("reset_from_done");
    cyc(0, 0, 0, S_IDLE, "idle_after_done");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
